// File: rtl/sync_fifo_junior_pkg.sv
// Shared defaults and pointer helper for the sync_fifo_junior block.
package sync_fifo_junior_pkg;

  localparam int unsigned DEFAULT_WIDTH_DATA = 8;
  localparam int unsigned DEFAULT_DEPTH      = 16;

  // Advance a circular-buffer pointer; depth is a power of two so masking wraps it.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1) & (depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_junior_if.sv
// Write/read strobes, data and status flags between a producer/consumer and the FIFO.
interface sync_fifo_junior_if
  import sync_fifo_junior_pkg::*;
#(
  parameter int unsigned WIDTH_DATA = DEFAULT_WIDTH_DATA
);

  logic                  write;
  logic                  read;
  logic [WIDTH_DATA-1:0] data_in;
  logic [WIDTH_DATA-1:0] data_out;
  logic                  fifo_empty;
  logic                  fifo_full;

  modport master (
    output write, read, data_in,
    input  data_out, fifo_empty, fifo_full
  );

  modport slave (
    input  write, read, data_in,
    output data_out, fifo_empty, fifo_full
  );

endinterface

// File: rtl/sync_fifo_junior_mem.sv
// Simple dual-port register file: synchronous write, registered read with clearable output.
module sync_fifo_junior_mem
  import sync_fifo_junior_pkg::*;
#(
  parameter int unsigned WIDTH_DATA = DEFAULT_WIDTH_DATA,
  parameter int unsigned DEPTH      = DEFAULT_DEPTH,
  parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [WIDTH_DATA-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [WIDTH_DATA-1:0] rdata
);

  logic [WIDTH_DATA-1:0] mem [DEPTH];

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register holds its value unless a read is performed; reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo_junior.sv
// Single-clock FIFO: pointers, occupancy counter, accept logic and registered flags.
module sync_fifo_junior
  import sync_fifo_junior_pkg::*;
#(
  parameter int unsigned WIDTH_DATA = DEFAULT_WIDTH_DATA,
  parameter int unsigned DEPTH      = DEFAULT_DEPTH
) (
  input logic               clk_i,
  input logic               rst_i,
  sync_fifo_junior_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt_c;
  logic              wr_acc_c;
  logic              rd_acc_c;

  // Accept decisions and next occupancy; a read frees a slot for a same-cycle write when full.
  always_comb begin
    rd_acc_c    = bus.read & ~bus.fifo_empty;
    wr_acc_c    = bus.write & (~bus.fifo_full | rd_acc_c);
    count_nxt_c = count;
    if (wr_acc_c && !rd_acc_c) begin
      count_nxt_c = count + CNT_W'(1);
    end else if (rd_acc_c && !wr_acc_c) begin
      count_nxt_c = count - CNT_W'(1);
    end
  end

  // Pointers, counter and flags; flags come from next count so they align with the pointers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      bus.fifo_empty <= 1'b1;
      bus.fifo_full  <= 1'b0;
    end else begin
      if (wr_acc_c) begin
        wr_ptr <= ADDR_W'(ptr_inc(32'(wr_ptr), DEPTH));
      end
      if (rd_acc_c) begin
        rd_ptr <= ADDR_W'(ptr_inc(32'(rd_ptr), DEPTH));
      end
      count          <= count_nxt_c;
      bus.fifo_empty <= (count_nxt_c == '0);
      bus.fifo_full  <= (count_nxt_c == CNT_W'(DEPTH));
    end
  end

  sync_fifo_junior_mem #(
    .WIDTH_DATA (WIDTH_DATA),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .clk   (clk_i),
    .rst   (rst_i),
    .we    (wr_acc_c),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .re    (rd_acc_c),
    .raddr (rd_ptr),
    .rdata (bus.data_out)
  );

endmodule

// File: tb/tb_sync_fifo_junior.sv
// Directed and randomized bench for sync_fifo_junior against a queue-based model.
module tb_sync_fifo_junior;

  localparam int unsigned WD    = 8;
  localparam int unsigned DEPTH = 16;

  logic clk_i = 1'b0;
  logic rst_i;

  sync_fifo_junior_if #(.WIDTH_DATA(WD)) bus ();

  sync_fifo_junior #(
    .WIDTH_DATA (WD),
    .DEPTH      (DEPTH)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // Reference model state
  logic [WD-1:0] q [$];
  logic [WD-1:0] exp_dout;
  int            n_checks = 0;
  int            n_fails  = 0;
  logic          last_rd_ok;

  task automatic chk(input string tag, input logic [WD-1:0] obs, input logic [WD-1:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // One clock edge with the given strobes; model updated from queue occupancy, outputs checked.
  task automatic step(input logic rst, input logic w, input logic r, input logic [WD-1:0] d,
                      input string tag);
    logic rd_ok, wr_ok;
    rst_i      = rst;
    bus.write  = w;
    bus.read   = r;
    bus.data_in = d;
    @(posedge clk_i);
    if (rst) begin
      q.delete();
      exp_dout = '0;
      rd_ok    = 1'b0;
    end else begin
      rd_ok = r && (q.size() > 0);
      wr_ok = w && ((q.size() < DEPTH) || rd_ok);
      if (rd_ok) exp_dout = q.pop_front();
      if (wr_ok) q.push_back(d);
    end
    last_rd_ok = rd_ok;
    #1;
    chk({tag, ".empty"}, WD'(bus.fifo_empty), WD'(q.size() == 0));
    chk({tag, ".full"},  WD'(bus.fifo_full),  WD'(q.size() == DEPTH));
    chk({tag, ".dout"},  bus.data_out, exp_dout);
  endtask

  initial begin
    int nw;
    int nr;
    logic w, r;
    rst_i       = 1'b1;
    bus.write   = 1'b0;
    bus.read    = 1'b0;
    bus.data_in = '0;
    exp_dout    = '0;
    last_rd_ok  = 1'b0;

    // 1. Reset with a write pending; the write must not be stored
    step(1'b1, 1'b1, 1'b0, 8'h77, "rst");
    chk("rst.empty_const", WD'(bus.fifo_empty), 8'h01);
    chk("rst.dout_const", bus.data_out, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h00, "rst_rd");

    // 2. Fill 0x01..0x10, then an ignored 17th write
    for (int i = 1; i <= 16; i++) step(1'b0, 1'b1, 1'b0, WD'(i), "fill");
    chk("fill.full_const", WD'(bus.fifo_full), 8'h01);
    step(1'b0, 1'b1, 1'b0, 8'h11, "fill17");

    // 3. Drain in order, then an ignored 17th read
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00, "drain");
      chk("drain.order", bus.data_out, WD'(i));
    end
    step(1'b0, 1'b0, 1'b1, 8'h00, "drain17");
    chk("drain17.hold", bus.data_out, 8'h10);

    // 4. 50 words through the buffer with occupancy kept small, across several wraps
    nw = 0;
    nr = 0;
    for (int k = 0; k < 400 && nr < 50; k++) begin
      w = (nw < 50) && (q.size() < 3) && ((q.size() == 0) || ($urandom_range(1, 0) == 1));
      r = (q.size() > 1) || ((nw == 50) && (q.size() > 0)) ||
          ((q.size() > 0) && ($urandom_range(1, 0) == 1));
      step(1'b0, w, r, WD'(nw + 1), "wrap");
      if (w) nw++;
      if (last_rd_ok) begin
        nr++;
        chk("wrap.seq", bus.data_out, WD'(nr));
      end
    end
    chk("wrap.count", WD'(nr), 8'd50);

    // Random mix of strobes and data
    for (int k = 0; k < 300; k++) begin
      step(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), WD'($urandom), "rand");
    end

    // 5a. Empty with simultaneous read and write: write only
    step(1'b1, 1'b0, 1'b0, 8'h00, "rst2");
    step(1'b0, 1'b1, 1'b1, 8'hAA, "emp_rw");
    chk("emp_rw.dout_const", bus.data_out, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h00, "emp_rw_rd");
    chk("emp_rw_rd.dout_const", bus.data_out, 8'hAA);

    // 5b. Full with simultaneous read and write: oldest out, stays full
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, WD'(8'h20 + i), "fill2");
    step(1'b0, 1'b1, 1'b1, 8'hC3, "full_rw");
    chk("full_rw.full_const", WD'(bus.fifo_full), 8'h01);
    chk("full_rw.dout_const", bus.data_out, 8'h20);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, 8'h00, "drain2");
    chk("drain2.last", bus.data_out, 8'hC3);

    // 6. Reset with 5 words stored, then a fresh word round-trips
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, WD'(8'h40 + i), "pre_rst");
    step(1'b1, 1'b0, 1'b0, 8'h00, "mid_rst");
    chk("mid_rst.dout_const", bus.data_out, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h5A, "post_wr");
    step(1'b0, 1'b0, 1'b1, 8'h00, "post_rd");
    chk("post_rd.dout_const", bus.data_out, 8'h5A);
    step(1'b0, 1'b0, 1'b1, 8'h00, "post_rd2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
